// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader
// Description : Streams a configuration bitstream into a daisy-chained slice
//               programming chain, with an optional ring-recirculating
//               checksum readback pass.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_loader #(
    parameter int WORDS  = 83,
    parameter int SLICES = 1,
    localparam int TOTAL = WORDS * SLICES,
    localparam int CW    = $clog2(TOTAL + 1)
) (
    input  logic          clk,
    input  logic          res,
    input  logic          start,
    input  logic          verify_en,
    input  logic [31:0]   cfg_data,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    output logic [31:0]   prog_data,
    output logic          prog_shft,
    input  logic [31:0]   chain_i,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [CW-1:0] word_cnt
);

    localparam logic [2:0] C_IDLE   = 3'd0;
    localparam logic [2:0] C_LOAD   = 3'd1;
    localparam logic [2:0] C_DRAIN  = 3'd2;
    localparam logic [2:0] C_VERIFY = 3'd3;
    localparam logic [2:0] C_DONE   = 3'd4;

    localparam logic [CW-1:0] C_TOTAL = CW'(TOTAL);
    localparam logic [CW-1:0] C_LAST  = CW'(TOTAL - 1);

    logic [2:0]    r_state;
    logic [CW-1:0] r_word_cnt;
    logic [CW-1:0] r_vcnt;
    logic [31:0]   r_ld_sum;
    logic [31:0]   r_rb_sum;
    logic [31:0]   r_prog_data;
    logic          r_prog_shft;
    logic          r_verify;
    logic          r_err;

    logic          w_accept;
    logic [31:0]   w_rb_next;

    assign cfg_ready = (r_state == C_LOAD) && (r_word_cnt < C_TOTAL);
    assign w_accept  = cfg_valid && cfg_ready;
    assign w_rb_next = r_rb_sum ^ chain_i;

    // During readback the chain output is fed straight back into its input,
    // so a full pass of TOTAL shifts leaves every slice register unchanged.
    assign prog_data = (r_state == C_VERIFY) ? chain_i : r_prog_data;
    assign prog_shft = r_prog_shft;
    assign busy      = (r_state != C_IDLE);
    assign done      = (r_state == C_DONE);
    assign err       = r_err;
    assign word_cnt  = r_word_cnt;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_state     <= C_IDLE;
            r_word_cnt  <= '0;
            r_vcnt      <= '0;
            r_ld_sum    <= '0;
            r_rb_sum    <= '0;
            r_prog_data <= '0;
            r_prog_shft <= 1'b0;
            r_verify    <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                C_IDLE: begin
                    r_prog_shft <= 1'b0;
                    if (start) begin
                        r_state    <= C_LOAD;
                        r_word_cnt <= '0;
                        r_ld_sum   <= '0;
                        r_rb_sum   <= '0;
                        r_err      <= 1'b0;
                        r_verify   <= verify_en;
                    end
                end
                C_LOAD: begin
                    // Shift only on the cycle following an accept; gaps hold the chain.
                    r_prog_shft <= w_accept;
                    if (w_accept) begin
                        r_prog_data <= cfg_data;
                        r_word_cnt  <= r_word_cnt + 1'b1;
                        r_ld_sum    <= r_ld_sum ^ cfg_data;
                        if (r_word_cnt == C_LAST) begin
                            r_state <= C_DRAIN;
                        end
                    end
                end
                C_DRAIN: begin
                    r_vcnt <= '0;
                    if (r_verify) begin
                        r_state     <= C_VERIFY;
                        r_prog_shft <= 1'b1;
                    end else begin
                        r_state     <= C_DONE;
                        r_prog_shft <= 1'b0;
                    end
                end
                C_VERIFY: begin
                    r_rb_sum <= w_rb_next;
                    r_vcnt   <= r_vcnt + 1'b1;
                    if (r_vcnt == C_LAST) begin
                        r_state     <= C_DONE;
                        r_prog_shft <= 1'b0;
                        r_err       <= (w_rb_next != r_ld_sum);
                    end
                end
                C_DONE: begin
                    r_prog_shft <= 1'b0;
                    r_state     <= C_IDLE;
                end
                default: begin
                    r_state     <= C_IDLE;
                    r_prog_shft <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_loader
// Description : Self-checking bench for prog_loader with behavioural chain models
//               for a 4-word and an 83-word configuration.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        res;
    logic        start     [2];
    logic        verify_en [2];
    logic        cfg_valid [2];
    logic [31:0] cfg_data  [2];

    logic        rdy_s, shft_s, busy_s, done_s, err_s;
    logic [31:0] pd_s;
    logic [2:0]  wc_s;
    logic        rdy_b, shft_b, busy_b, done_b, err_b;
    logic [31:0] pd_b;
    logic [6:0]  wc_b;

    logic [31:0] ch_s [4];
    logic [31:0] ch_b [83];
    logic        stuck;

    logic [31:0] wq [83];
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic        rdy;
        logic        shft;
        logic        busy;
        logic        done;
        logic        err;
        logic [7:0]  wc;
        logic [31:0] pd;
        logic [31:0] ci;
    } obs_t;
    obs_t ob [2];

    prog_loader #(.WORDS(4), .SLICES(1)) u_small (
        .clk(clk), .res(res), .start(start[0]), .verify_en(verify_en[0]),
        .cfg_data(cfg_data[0]), .cfg_valid(cfg_valid[0]), .cfg_ready(rdy_s),
        .prog_data(pd_s), .prog_shft(shft_s), .chain_i(ch_s[3]),
        .busy(busy_s), .done(done_s), .err(err_s), .word_cnt(wc_s)
    );

    prog_loader #(.WORDS(83), .SLICES(1)) u_big (
        .clk(clk), .res(res), .start(start[1]), .verify_en(verify_en[1]),
        .cfg_data(cfg_data[1]), .cfg_valid(cfg_valid[1]), .cfg_ready(rdy_b),
        .prog_data(pd_b), .prog_shft(shft_b), .chain_i(ch_b[82]),
        .busy(busy_b), .done(done_b), .err(err_b), .word_cnt(wc_b)
    );

    // Slice chain models: register 0 takes prog_data, the last register is chain_i.
    always @(posedge clk) begin
        if (shft_s) begin
            for (int i = 3; i > 0; i--) ch_s[i] <= ch_s[i-1];
            ch_s[0] <= pd_s;
        end
    end

    always @(posedge clk) begin
        if (shft_b) begin
            for (int i = 82; i > 0; i--)
                ch_b[i] <= (i == 40 && stuck) ? (ch_b[i-1] | 32'h1) : ch_b[i-1];
            ch_b[0] <= pd_b;
        end
    end

    always_comb begin
        ob[0] = {rdy_s, shft_s, busy_s, done_s, err_s, {5'd0, wc_s}, pd_s, ch_s[3]};
        ob[1] = {rdy_b, shft_b, busy_b, done_b, err_b, {1'b0, wc_b}, pd_b, ch_b[82]};
    end

    function automatic logic [31:0] chw(input int d, input int i);
        return (d != 0) ? ch_b[i] : ch_s[i];
    endfunction

    // Full load scenario; expectations come from the word list and the chain model.
    task automatic run_load(input int d, input int gap, input bit ver, input bit hold_valid,
                            input bit poke_start, input bit mask0, input bit exp_err,
                            input bit ideal);
        int tot, idx, cyc, gl, vc;
        bit v, ok;
        logic [31:0] snap [83];
        tot = (d != 0) ? 83 : 4;
        for (int i = 0; i < tot; i++) begin
            wq[i] = $urandom;
            if (mask0) wq[i][0] = 1'b0;
        end
        @(posedge clk); #1;
        start[d] = 1'b1; verify_en[d] = ver;
        @(posedge clk); #1;
        start[d] = 1'b0; verify_en[d] = 1'($urandom);
        n_cmp++;
        if ({ob[d].busy, ob[d].wc, ob[d].err, ob[d].shft} !== {1'b1, 8'd0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL load_entry d=%0d: busy/wc/err/shft got %b/%0d/%b/%b want 1/0/0/0",
                     d, ob[d].busy, ob[d].wc, ob[d].err, ob[d].shft);
        end
        idx = 0; cyc = 0; gl = 0;
        while (idx < tot && cyc < tot * (gap + 1) + 20) begin
            v = (gl == 0);
            if (gl > 0) gl--;
            cfg_valid[d] = v;
            cfg_data[d]  = v ? wq[idx] : $urandom;
            if (poke_start && idx == 1) start[d] = 1'b1;
            n_cmp++;
            if (ob[d].rdy !== 1'b1) begin
                n_bad++;
                $display("FAIL ready_in_load d=%0d idx=%0d: got %b want 1", d, idx, ob[d].rdy);
            end
            @(posedge clk); #1;
            start[d] = 1'b0; cyc++;
            n_cmp++;
            if (ob[d].shft !== v) begin
                n_bad++;
                $display("FAIL shft_after_cycle d=%0d idx=%0d: got %b want %b", d, idx, ob[d].shft, v);
            end
            if (v) begin
                n_cmp++;
                if (ob[d].pd !== wq[idx]) begin
                    n_bad++;
                    $display("FAIL prog_data d=%0d idx=%0d: got %h want %h", d, idx, ob[d].pd, wq[idx]);
                end
                idx++; gl = gap;
            end
        end
        n_cmp++;
        if (idx != tot) begin
            n_bad++;
            $display("FAIL load_timeout d=%0d: accepted %0d want %0d", d, idx, tot);
        end
        cfg_valid[d] = hold_valid; cfg_data[d] = $urandom;
        n_cmp++;
        if ({ob[d].wc, ob[d].rdy, ob[d].busy, ob[d].done} !== {8'(tot), 1'b0, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL drain d=%0d: wc/rdy/busy/done got %0d/%b/%b/%b want %0d/0/1/0",
                     d, ob[d].wc, ob[d].rdy, ob[d].busy, ob[d].done, tot);
        end
        @(posedge clk); #1;
        if (ideal) begin
            ok = 1'b1;
            for (int i = 0; i < tot; i++) begin
                if (chw(d, tot - 1 - i) !== wq[i]) ok = 1'b0;
                snap[i] = chw(d, i);
            end
            n_cmp++;
            if (!ok) begin
                n_bad++;
                $display("FAIL chain_after_load d=%0d: got first %h want %h", d, chw(d, tot-1), wq[0]);
            end
        end
        if (ver) begin
            vc = 0;
            while (ob[d].done !== 1'b1 && vc < tot + 10) begin
                n_cmp++;
                if (ob[d].shft !== 1'b1 || ob[d].pd !== ob[d].ci) begin
                    n_bad++;
                    $display("FAIL verify_ring d=%0d cyc=%0d: shft %b pd %h want 1 %h",
                             d, vc, ob[d].shft, ob[d].pd, ob[d].ci);
                end
                @(posedge clk); #1;
                vc++;
            end
            n_cmp++;
            if (vc != tot) begin
                n_bad++;
                $display("FAIL verify_len d=%0d: got %0d want %0d", d, vc, tot);
            end
            if (ideal) begin
                ok = 1'b1;
                for (int i = 0; i < tot; i++) if (chw(d, i) !== snap[i]) ok = 1'b0;
                n_cmp++;
                if (!ok) begin
                    n_bad++;
                    $display("FAIL chain_restored d=%0d: got reg0 %h want %h", d, chw(d, 0), snap[0]);
                end
            end
        end
        n_cmp++;
        if ({ob[d].done, ob[d].shft, ob[d].busy, ob[d].err, ob[d].wc} !==
            {1'b1, 1'b0, 1'b1, exp_err, 8'(tot)}) begin
            n_bad++;
            $display("FAIL done_state d=%0d: done/shft/busy/err/wc got %b/%b/%b/%b/%0d want 1/0/1/%b/%0d",
                     d, ob[d].done, ob[d].shft, ob[d].busy, ob[d].err, ob[d].wc, exp_err, tot);
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({ob[d].done, ob[d].shft, ob[d].busy, ob[d].err, ob[d].rdy, ob[d].wc} !==
            {1'b0, 1'b0, 1'b0, exp_err, 1'b0, 8'(tot)}) begin
            n_bad++;
            $display("FAIL idle_after d=%0d: done/shft/busy/err/rdy/wc got %b/%b/%b/%b/%b/%0d want 0/0/0/%b/0/%0d",
                     d, ob[d].done, ob[d].shft, ob[d].busy, ob[d].err, ob[d].rdy, ob[d].wc, exp_err, tot);
        end
        cfg_valid[d] = 1'b0;
    endtask

    task automatic test_reset();
        res = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if ({ob[d].rdy, ob[d].shft, ob[d].busy, ob[d].done, ob[d].err, ob[d].wc, ob[d].pd} !== '0) begin
                n_bad++;
                $display("FAIL reset_state d=%0d: rdy/shft/busy/done/err/wc/pd got %b/%b/%b/%b/%b/%0d/%h want all 0",
                         d, ob[d].rdy, ob[d].shft, ob[d].busy, ob[d].done, ob[d].err, ob[d].wc, ob[d].pd);
            end
        end
        res = 1'b0;
    endtask

    task automatic test_continuous();
        run_load(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_gaps();
        run_load(0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_verify_ideal();
        run_load(1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_stuck_bit();
        stuck = 1'b1;
        run_load(1, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (ob[1].err !== 1'b1) begin
            n_bad++;
            $display("FAIL err_held_idle: got %b want 1", ob[1].err);
        end
        stuck = 1'b0;
        // A fresh load must clear the sticky error on its start edge.
        run_load(1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_start_ignored();
        run_load(0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid_load();
        @(posedge clk); #1;
        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cfg_valid[0] = 1'b1; cfg_data[0] = $urandom;
            @(posedge clk); #1;
        end
        res = 1'b1;
        #1;
        n_cmp++;
        if ({ob[0].rdy, ob[0].shft, ob[0].busy, ob[0].done, ob[0].err, ob[0].wc, ob[0].pd} !== '0) begin
            n_bad++;
            $display("FAIL async_reset_mid_load: rdy/shft/busy/done/err/wc/pd got %b/%b/%b/%b/%b/%0d/%h want all 0",
                     ob[0].rdy, ob[0].shft, ob[0].busy, ob[0].done, ob[0].err, ob[0].wc, ob[0].pd);
        end
        cfg_valid[0] = 1'b0;
        @(posedge clk); #1;
        res = 1'b0;
        run_load(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 4; k++)
            run_load(0, int'($urandom_range(0, 3)), 1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        res = 1'b1;
        stuck = 1'b0;
        for (int d = 0; d < 2; d++) begin
            start[d] = 1'b0; verify_en[d] = 1'b0; cfg_valid[d] = 1'b0; cfg_data[d] = '0;
        end
        test_reset();
        test_continuous();
        test_gaps();
        test_verify_ideal();
        test_stuck_bit();
        test_start_ignored();
        test_reset_mid_load();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
